// File: rtl/ram_sync_clr.sv
// ram_sync_clr: parametrised single-port synchronous RAM with a registered
// read, a one-cycle valid strobe and a selectable read/write collision
// policy (READ_MODE 0 = read-first, 1 = write-first).
// Optional feature macro: RAM_CLEAR_EN. When defined, a clear sequencer
// zeroes every location after each reset and raises busy while it runs.
module ram_sync_clr #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int READ_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage: no reset so the array maps onto block RAM.
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              accept;     // user requests are honoured this edge
  logic              clearing;   // sequencer owns the write port this edge
  logic [ADDR_W-1:0] clr_addr;   // location being zeroed
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_bypass;  // write-first collision returns data_in
  logic [DATA_W-1:0] data_out_reg;
  logic              valid_reg;

`ifdef RAM_CLEAR_EN
  // RESET is the pre-reset power-up encoding; a reset edge always lands
  // in CLEAR so the sweep restarts from address 0.
  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_IDLE  = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;

  // Next-state logic for the clear sequencer.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      ST_CLEAR: begin
        clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
        if (clr_cnt_reg == {ADDR_W{1'b1}}) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        state_next = ST_IDLE;
      end
      ST_RESET: begin
        state_next   = ST_CLEAR;
        clr_cnt_next = '0;
      end
      default: begin
        state_next   = ST_CLEAR;
        clr_cnt_next = '0;
      end
    endcase
  end

  // Sequencer state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  assign clearing = (state_reg == ST_CLEAR);
  assign accept   = (state_reg == ST_IDLE);
  assign clr_addr = clr_cnt_reg;
  assign busy     = clearing;
`else
  assign clearing = 1'b0;
  assign accept   = 1'b1;
  assign clr_addr = '0;
  assign busy     = 1'b0;
`endif

  assign wr_bypass = (READ_MODE != 0) && we;

  // Write-port arbitration: the sequencer wins, and nothing is written on
  // a reset edge.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = address;
    mem_wdata = data_in;
    if (!rst) begin
      if (clearing) begin
        mem_we    = 1'b1;
        mem_addr  = clr_addr;
        mem_wdata = '0;
      end else if (accept && we) begin
        mem_we = 1'b1;
      end
    end
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Registered read with one-cycle valid; data_out holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
    end else if (accept && re) begin
      valid_reg <= 1'b1;
      if (wr_bypass) begin
        data_out_reg <= data_in;
      end else begin
        data_out_reg <= mem[address];
      end
    end else begin
      valid_reg <= 1'b0;
    end
  end

  assign data_out = data_out_reg;
  assign valid    = valid_reg;

endmodule

// File: tb/tb_ram_sync_clr.sv
// Directed bench for ram_sync_clr: read-first (u0) and write-first (u1)
// 16x8 instances driven in lockstep, plus a 64x12 instance (u2).
// Clear-sequencer steps are compiled only when RAM_CLEAR_EN is defined.
module tb_ram_sync_clr;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, re;
  logic [3:0]  addr;
  logic [7:0]  din;
  logic [7:0]  dout0, dout1;
  logic        valid0, valid1, busy0, busy1;
  logic        we2, re2;
  logic [5:0]  addr2;
  logic [11:0] din2;
  logic [11:0] dout2;
  logic        valid2, busy2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_sync_clr #(.DATA_W(8), .ADDR_W(4), .READ_MODE(0)) u0 (
    .clk(clk), .rst(rst), .we(we), .re(re), .address(addr), .data_in(din),
    .data_out(dout0), .valid(valid0), .busy(busy0));

  ram_sync_clr #(.DATA_W(8), .ADDR_W(4), .READ_MODE(1)) u1 (
    .clk(clk), .rst(rst), .we(we), .re(re), .address(addr), .data_in(din),
    .data_out(dout1), .valid(valid1), .busy(busy1));

  ram_sync_clr #(.DATA_W(12), .ADDR_W(6), .READ_MODE(0)) u2 (
    .clk(clk), .rst(rst), .we(we2), .re(re2), .address(addr2), .data_in(din2),
    .data_out(dout2), .valid(valid2), .busy(busy2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      $display("vec %0d %s observed=0x%0h ok", n_vec, tag, obs);
    else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    int  cnt2;
    bit  saw_valid;
    logic [7:0] exp8;

    rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; din = '0;
    we2 = 1'b0; re2 = 1'b0; addr2 = '0; din2 = '0;
    tick();
    tick();
    check("rst_dout0", dout0, 0);
    check("rst_valid0", valid0, 0);
    check("rst_dout1", dout1, 0);
    check("rst_valid1", valid1, 0);
`ifdef RAM_CLEAR_EN
    check("rst_busy0", busy0, 1);
    check("rst_busy2", busy2, 1);

    // Release reset with a write+read to address 3 pending during CLEAR.
    rst = 1'b0; we = 1'b1; re = 1'b1; addr = 4'd3; din = 8'h55;
    cnt = 0;
    saw_valid = 1'b0;
    do begin
      tick();
      cnt++;
      if (valid0 || valid1) saw_valid = 1'b1;
    end while (busy0 && cnt < 200);
    we = 1'b0; re = 1'b0;
    check("clr_busy_edges", cnt, 16);
    check("clr_no_valid", saw_valid, 0);
    cnt2 = cnt;
    while (busy2 && cnt2 < 300) begin
      tick();
      cnt2++;
    end
    check("clr_busy_edges_w64", cnt2, 64);
    re = 1'b1; addr = 4'd3;
    tick();
    re = 1'b0;
    check("clr_blocked_wr", dout0, 8'h00);
`else
    check("rst_busy0", busy0, 0);
    check("rst_busy2", busy2, 0);
    rst = 1'b0;
`endif

    // Fill with i*2, then read back-to-back.
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; addr = 4'(i); din = 8'(i * 2);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      re = 1'b1; addr = 4'(i);
      tick();
      exp8 = 8'(i * 2);
      check($sformatf("fill_rd0_a%0d", i), dout0, exp8);
      check($sformatf("fill_valid0_a%0d", i), valid0, 1);
      check($sformatf("fill_rd1_a%0d", i), dout1, exp8);
    end
    re = 1'b0;
    tick();
    check("idle_valid_low", valid0, 0);
    check("idle_dout_hold", dout0, 8'h1E);

    // Collision at address 7.
    we = 1'b1; addr = 4'd7; din = 8'h11;
    tick();
    we = 1'b1; re = 1'b1; din = 8'h22;
    tick();
    check("coll_rd_first", dout0, 8'h11);
    check("coll_wr_first", dout1, 8'h22);
    check("coll_valid", valid1, 1);
    we = 1'b0;
    tick();
    re = 1'b0;
    check("coll_after_m0", dout0, 8'h22);
    check("coll_after_m1", dout1, 8'h22);

    // Wide/deep instance: extremes of address space must not alias.
    we2 = 1'b1; addr2 = 6'd63; din2 = 12'hFFF;
    tick();
    addr2 = 6'd0; din2 = 12'h001;
    tick();
    we2 = 1'b0; re2 = 1'b1; addr2 = 6'd63;
    tick();
    check("w12_a63", dout2, 12'hFFF);
    addr2 = 6'd0;
    tick();
    re2 = 1'b0;
    check("w12_a0", dout2, 12'h001);
    check("w12_valid", valid2, 1);

`ifdef RAM_CLEAR_EN
    // Reset clears a pre-loaded word.
    we = 1'b1; addr = 4'd5; din = 8'hAA;
    tick();
    we = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("pulse_busy", busy0, 1);
    check("pulse_dout", dout0, 0);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (busy0 && cnt < 200);
    check("pulse_busy_edges", cnt, 16);
    re = 1'b1; addr = 4'd5;
    tick();
    re = 1'b0;
    check("pulse_a5_zero", dout0, 8'h00);

    // Reset after 6 clear edges restarts the sweep.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("mid_busy_6", busy0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy_rst", busy0, 1);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (busy0 && cnt < 200);
    check("mid_busy_edges", cnt, 16);
`else
    // Reset mid-traffic keeps memory; write on the reset edge is dropped.
    we = 1'b1; addr = 4'd2; din = 8'h77;
    tick();
    rst = 1'b1; din = 8'h99;
    tick();
    rst = 1'b0; we = 1'b0;
    check("mt_busy", busy0, 0);
    check("mt_dout", dout0, 0);
    check("mt_valid", valid0, 0);
    re = 1'b1;
    tick();
    re = 1'b0;
    check("mt_keep_a2", dout0, 8'h77);
    check("mt_first_edge_valid", valid0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_sync_clr.md
# ram_sync_clr

Parametrised single-port synchronous RAM: successor to the fixed 16x8 asynchronous-read RAM. Width and depth are generic, and reads are registered with a one-cycle `valid` strobe. The read/write collision policy is selectable. An optional hardware clear sequencer zeroes every location after reset. It serves as the general-purpose scratch memory for the datapath blocks in the digital-circuits coursework designs.

## Interface
- `DATA_W`, default 8: word width in bits, ≥1.
- `ADDR_W`, default 4: address width; depth = 2^ADDR_W words, ≥1.
- `READ_MODE`, default 0: collision policy.
  - 0 = read-first: a read returns the old word.
  - 1 = write-first: a read returns `data_in`.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous active-high reset.
- `we`, in, 1: write enable.
- `re`, in, 1: read enable.
- `address`, in, ADDR_W: word address, shared by read and write.
- `data_in`, in, DATA_W: write data.
- `data_out`, out, DATA_W: registered read data; holds until the next accepted read.
- `valid`, out, 1: high for exactly one cycle after each accepted read.
- `busy`, out, 1: high while the clear sequencer runs; requests are ignored while high.

## Operation
- States are RESET, CLEAR and IDLE.
  - CLEAR exists only with `RAM_CLEAR_EN`.
  - Without `RAM_CLEAR_EN`, the block leaves reset directly to IDLE.
- Edge with `rst`=1:
  - `data_out` ← 0, `valid` ← 0, clear counter ← 0.
  - State ← CLEAR (`busy` ← 1) if the feature is compiled in, else IDLE (`busy` ← 0).
  - Memory array is not written on this edge.
- CLEAR: each edge with `rst`=0 writes `mem[clr_cnt]` ← 0 and increments `clr_cnt`.
  - On the edge writing location 2^ADDR_W−1: state ← IDLE, `busy` ← 0.
  - `we` and `re` are ignored throughout: no write, `valid` stays 0, `data_out` unchanged.
- IDLE, accepted write (`we`=1): `mem[address]` ← `data_in` at the edge.
- IDLE, accepted read (`re`=1): at the edge, `data_out` ← word and `valid` ← 1.
  - Without `re`, `valid` ← 0 and `data_out` holds.
- `we`=1 and `re`=1 on the same edge (same address by construction):
  - READ_MODE=0: `data_out` ← previous contents.
  - READ_MODE=1: `data_out` ← `data_in`.
  - The write always completes.
- Address covers the full power-of-two depth; there is no out-of-range case.
- Reset asserted mid-CLEAR or mid-traffic takes effect at that edge and restarts CLEAR from address 0.
  - Locations already zeroed stay zero.
  - Writes accepted before reset are retained, then overwritten by CLEAR if compiled in.

## Timing
- Read latency: 1 cycle. Address and `re` sampled at edge N; `data_out` and `valid` valid after edge N.
- Write latency: 1 cycle. A read of the same address at edge N+1 returns the new word.
- Back-to-back reads: one per cycle, with `valid` held high continuously.
- Clear duration: `busy` is high for exactly 2^ADDR_W edges after the first edge with `rst`=0.
  - The first request is accepted on edge 2^ADDR_W+1.
- Reset values:
  - `data_out` = 0, `valid` = 0.
  - `busy` = 1 with `RAM_CLEAR_EN`, 0 without.
- No combinational path from inputs to outputs.

## Configuration
- Macro: `RAM_CLEAR_EN`.
- Defined:
  - CLEAR state and ADDR_W-bit counter are present.
  - Memory reads all-zero after every reset.
  - `busy` behaves as above.
- Undefined:
  - No sequencer; `busy` is tied to 0.
  - The block accepts requests on the first edge after reset.
  - Memory contents after reset are unchanged (X at power-up in simulation).

## Test plan
- Fill and readback (DATA_W=8, ADDR_W=4, READ_MODE=0):
  - Write `i*2` to address i for i=0..15, then read 0..15 back to back.
  - Required: `data_out` = 0x00,0x02,…,0x1E, with `valid` high on 16 consecutive cycles.
- Clear (`RAM_CLEAR_EN` defined):
  - Pre-load address 5 with 0xAA, pulse `rst` for 1 cycle, then read address 5 as soon as `busy` falls.
  - Required: `busy` high for exactly 16 edges, `data_out` = 0x00.
- Clear blocking:
  - Assert `we`=1, `address`=3, `data_in`=0x55 during CLEAR.
  - Required: address 3 reads 0x00 afterwards, and `valid` never rises during CLEAR.
- Collision:
  - Address 7 holds 0x11; drive `we`=`re`=1 with `data_in`=0x22.
  - Required: READ_MODE=0 gives `data_out`=0x11; READ_MODE=1 gives 0x22. A following read returns 0x22 in both modes.
- Reset mid-clear:
  - Assert `rst` after 6 clear edges.
  - Required: `busy` stays high, the counter restarts, and `busy` falls exactly 16 edges after the second release.
- Generic width (DATA_W=12, ADDR_W=6):
  - Write 0xFFF to address 63 and 0x001 to address 0, then read both.
  - Required: exact values returned, no aliasing between 0 and 63.
